// File: rtl/clken_pkg.sv
// -----------------------------------------------------------------------------
// clken_pkg
// Shared definitions for the clken_gen clock-enable generator:
//   - clken_state_e : supervisor state encoding
//   - CLKEN_MAX_CH  : largest supported channel count
//   - clamp_phase() : limits a phase value to the channel divide value
// -----------------------------------------------------------------------------
package clken_pkg;

    localparam int CLKEN_MAX_CH = 16;

    typedef enum logic [1:0] {
        RESET     = 2'd0,
        WAIT_LOCK = 2'd1,
        RUN       = 2'd2,
        ALIGN     = 2'd3
    } clken_state_e;

    // A phase beyond the end of the period would never fire; pin it to the
    // last position of the period instead.
    function automatic logic [31:0] clamp_phase(input logic [31:0] phase,
                                                input logic [31:0] div);
        return (phase > div) ? div : phase;
    endfunction

endpackage

// File: rtl/clken_chan.sv
// -----------------------------------------------------------------------------
// clken_chan
// One enable channel: period counter, enable compare, reset-release flag and
// (with CLKEN_SQUARE_EN defined) the 50 % square enable.
//
// Ports
//   refclk     in  clock
//   rst        in  synchronous active-high reset
//   run_i      in  supervisor is in RUN on the coming cycle
//   restart_i  in  coming cycle is RUN k=0
//   drop_i     in  coming cycle is outside RUN/ALIGN, reassert rst_o
//   div_i      in  divide value (period = div_i+1) for the coming cycle
//   phase_i    in  enable position within the period
//   ce_o       out one-cycle enable pulse
//   rst_o      out channel reset, released after the first ce_o pulse
//   sq_o       out square enable (CLKEN_SQUARE_EN only)
// -----------------------------------------------------------------------------
module clken_chan
    import clken_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             run_i,
    input  logic             restart_i,
    input  logic             drop_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic [DIV_W-1:0] phase_i,
    output logic             ce_o,
    output logic             rst_o
`ifdef CLKEN_SQUARE_EN
    ,
    output logic             sq_o
`endif
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] phase_eff;
    logic             ce_q, ce_d;
    logic             hold_q, hold_d;

    assign phase_eff = DIV_W'(clamp_phase(32'(phase_i), 32'(div_i)));

    // Outputs are computed from the counter's next value so that every output
    // is a flop and k=0 is visible on the first RUN cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (!run_i || restart_i) begin
            cnt_d = '0;
        end else if (cnt_q >= div_i) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        ce_d   = run_i && (cnt_d == phase_eff);
        hold_d = drop_i ? 1'b1 : (hold_q & ~ce_q);
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            cnt_q  <= '0;
            ce_q   <= 1'b0;
            hold_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            ce_q   <= ce_d;
            hold_q <= hold_d;
        end
    end

    assign ce_o  = ce_q;
    assign rst_o = hold_q;

`ifdef CLKEN_SQUARE_EN
    logic [DIV_W:0] half;
    logic           sq_q, sq_d;

    // ceil((div+1)/2) in DIV_W+1 bits so an all-ones divide does not wrap.
    assign half = ({1'b0, div_i} + (DIV_W+1)'(2)) >> 1;

    always_comb begin
        sq_d = run_i && ({1'b0, cnt_d} < half);
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            sq_q <= 1'b0;
        end else begin
            sq_q <= sq_d;
        end
    end

    assign sq_o = sq_q;
`endif

endmodule

// File: rtl/clken_gen.sv
// -----------------------------------------------------------------------------
// clken_gen
// Multi-channel clock-enable generator with PLL lock supervision. Filters the
// asynchronous lock indication, sequences the channels and holds the
// per-channel divide/phase shadow registers written through a valid/ready port.
// Optional feature macro: CLKEN_SQUARE_EN (adds sq_out square enables).
//
// State   | meaning
// RESET   | first cycle after rst, outputs held in reset
// WAIT_LOCK| counting consecutive synchronised-lock cycles
// RUN     | channels counting, enables active
// ALIGN   | one idle cycle after a config write, then RUN restarts at k=0
//
// Ports
//   refclk     in  single clock
//   rst        in  synchronous active-high reset
//   locked_in  in  raw PLL lock (asynchronous)
//   cfg_valid  in  config request
//   cfg_ready  out config can be accepted (WAIT_LOCK, RUN)
//   cfg_ch     in  target channel; out-of-range values are accepted and ignored
//   cfg_div    in  divide value, period = cfg_div+1
//   cfg_phase  in  enable position within the period
//   locked     out filtered lock
//   ce_out     out per-channel one-cycle enables
//   rst_out    out per-channel synchronous resets
//   sq_out     out per-channel square enables (CLKEN_SQUARE_EN only)
// -----------------------------------------------------------------------------
module clken_gen
    import clken_pkg::*;
#(
    parameter int NUM_CH   = 3,
    parameter int DIV_W    = 8,
    parameter int LOCK_CYC = 1024,
    parameter int DEF_DIV  = 1
) (
    input  logic                                           refclk,
    input  logic                                           rst,
    input  logic                                           locked_in,
    input  logic                                           cfg_valid,
    output logic                                           cfg_ready,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
    input  logic [DIV_W-1:0]                               cfg_div,
    input  logic [DIV_W-1:0]                               cfg_phase,
    output logic                                           locked,
    output logic [NUM_CH-1:0]                              ce_out,
    output logic [NUM_CH-1:0]                              rst_out
`ifdef CLKEN_SQUARE_EN
    ,
    output logic [NUM_CH-1:0]                              sq_out
`endif
);

    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CH_LIMIT = (NUM_CH < CLKEN_MAX_CH) ? NUM_CH : CLKEN_MAX_CH;
    localparam int LCNT_W   = $clog2(LOCK_CYC + 1);

    clken_state_e state_q, state_d;

    logic              sync1_q, sync2_q;
    logic [LCNT_W-1:0] lcnt_q, lcnt_d;
    logic              xfer, ch_ok;
    logic              run_nx, restart_nx, drop_nx;

    logic [DIV_W-1:0] div_q   [NUM_CH];
    logic [DIV_W-1:0] div_d   [NUM_CH];
    logic [DIV_W-1:0] phase_q [NUM_CH];
    logic [DIV_W-1:0] phase_d [NUM_CH];

    // Two-flop synchroniser for the asynchronous lock input.
    always_ff @(posedge refclk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= locked_in;
            sync2_q <= sync1_q;
        end
    end

    assign xfer  = cfg_valid && cfg_ready;
    assign ch_ok = 32'(cfg_ch) < 32'(CH_LIMIT);

    // Lock filter: only counts in WAIT_LOCK, any low sample restarts it.
    always_comb begin
        lcnt_d = '0;
        if (state_q == WAIT_LOCK && sync2_q) begin
            lcnt_d = lcnt_q + 1'b1;
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            lcnt_q <= '0;
        end else begin
            lcnt_q <= lcnt_d;
        end
    end

    // State register
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q <= RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; loss of lock takes priority over a pending ALIGN.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RESET: state_d = WAIT_LOCK;
            WAIT_LOCK: begin
                if (sync2_q && lcnt_q == LCNT_W'(LOCK_CYC - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!sync2_q) begin
                    state_d = WAIT_LOCK;
                end else if (xfer) begin
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                state_d = sync2_q ? RUN : WAIT_LOCK;
            end
            default: state_d = RESET;
        endcase
    end

    // Outputs and channel controls
    always_comb begin
        cfg_ready  = (state_q == WAIT_LOCK) || (state_q == RUN);
        locked     = (state_q == RUN) || (state_q == ALIGN);
        run_nx     = (state_d == RUN);
        restart_nx = run_nx && (state_q != RUN);
        drop_nx    = !((state_d == RUN) || (state_d == ALIGN));
    end

    // Shadow registers. Channels see the next-state value so a write landing
    // on the WAIT_LOCK->RUN edge is already in effect at k=0.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            div_d[c]   = div_q[c];
            phase_d[c] = phase_q[c];
            if (xfer && ch_ok && cfg_ch == CH_W'(c)) begin
                div_d[c]   = cfg_div;
                phase_d[c] = cfg_phase;
            end
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                div_q[c]   <= DIV_W'(DEF_DIV);
                phase_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                div_q[c]   <= div_d[c];
                phase_q[c] <= phase_d[c];
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        clken_chan #(
            .DIV_W (DIV_W)
        ) u_chan (
            .refclk    (refclk),
            .rst       (rst),
            .run_i     (run_nx),
            .restart_i (restart_nx),
            .drop_i    (drop_nx),
            .div_i     (div_d[c]),
            .phase_i   (phase_d[c]),
            .ce_o      (ce_out[c]),
            .rst_o     (rst_out[c])
`ifdef CLKEN_SQUARE_EN
            ,
            .sq_o      (sq_out[c])
`endif
        );
    end

endmodule

// File: tb/tb_clken_gen.sv
// -----------------------------------------------------------------------------
// tb_clken_gen
// Directed bench for clken_gen with NUM_CH=3, DIV_W=8, LOCK_CYC=8, DEF_DIV=1.
// Inputs change 1 time unit after the rising edge and outputs are sampled at
// the same point, so each tick() advances exactly one cycle.
// -----------------------------------------------------------------------------
module tb_clken_gen;

    logic       refclk = 1'b0;
    logic       rst;
    logic       locked_in;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_div;
    logic [7:0] cfg_phase;
    logic       locked;
    logic [2:0] ce_out;
    logic [2:0] rst_out;
`ifdef CLKEN_SQUARE_EN
    logic [2:0] sq_out;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Expected ce_out after reloading ch1 to div=4 phase=7 (clamped to 4),
    // ch0/ch2 at div=1 phase=0; k = 0..9.
    logic [2:0] ce_b [10] = '{3'b101, 3'b000, 3'b101, 3'b000, 3'b111,
                              3'b000, 3'b101, 3'b000, 3'b101, 3'b010};
    // After relock: ch0 div0, ch1 div4 ph4, ch2 div2 ph1; k = 0..5.
    logic [2:0] ce_e  [6] = '{3'b001, 3'b101, 3'b001, 3'b001, 3'b111, 3'b001};
    logic [2:0] rst_e [6] = '{3'b111, 3'b110, 3'b010, 3'b010, 3'b010, 3'b000};
`ifdef CLKEN_SQUARE_EN
    logic [2:0] sq_e  [6] = '{3'b111, 3'b111, 3'b011, 3'b101, 3'b101, 3'b011};
`endif

    always #5 refclk = ~refclk;

    clken_gen #(
        .NUM_CH   (3),
        .DIV_W    (8),
        .LOCK_CYC (8),
        .DEF_DIV  (1)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .locked_in (locked_in),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_phase (cfg_phase),
        .locked    (locked),
        .ce_out    (ce_out),
        .rst_out   (rst_out)
`ifdef CLKEN_SQUARE_EN
        ,
        .sq_out    (sq_out)
`endif
    );

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [7:0] dv, input logic [7:0] ph);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_div   = dv;
        cfg_phase = ph;
    endtask

    initial begin
        rst       = 1'b1;
        locked_in = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
        cfg_phase = '0;

        // Reset state
        repeat (3) tick();
        check("rst_locked", locked, 0);
        check("rst_ce", ce_out, 3'b000);
        check("rst_rstout", rst_out, 3'b111);
        check("rst_ready", cfg_ready, 0);
`ifdef CLKEN_SQUARE_EN
        check("rst_sq", sq_out, 3'b000);
`endif
        rst = 1'b0;
        tick();
        check("waitlock_ready", cfg_ready, 1);
        tick();

        // Lock-up: raised now (cycle t), locked expected at t+10
        locked_in = 1'b1;
        repeat (9) tick();
        check("lockup_t9_locked", locked, 0);
        tick();
        check("lockup_t10_locked", locked, 1);
        check("lockup_k0_ce", ce_out, 3'b111);
        check("lockup_k0_rstout", rst_out, 3'b111);
        tick();
        check("lockup_k1_ce", ce_out, 3'b000);
        check("lockup_k1_rstout", rst_out, 3'b000);
        tick();
        check("lockup_k2_ce", ce_out, 3'b111);

        // Reload ch1 to div=4 phase=7 while in RUN
        cfg_write(2'd1, 8'd4, 8'd7);
        check("reload_ready", cfg_ready, 1);
        tick();
        cfg_valid = 1'b0;
        check("reload_align_ce", ce_out, 3'b000);
        check("reload_align_locked", locked, 1);
        check("reload_align_ready", cfg_ready, 0);
        check("reload_align_rstout", rst_out, 3'b000);
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("reload_ce_k%0d", k), ce_out, ce_b[k]);
        end

        // Out-of-range channel: accepted, ignored, ALIGN still taken
        cfg_write(2'd3, 8'd0, 8'd0);
        check("badch_ready", cfg_ready, 1);
        tick();
        cfg_valid = 1'b0;
        check("badch_align_ce", ce_out, 3'b000);
        check("badch_align_ready", cfg_ready, 0);
        tick();
        check("badch_k0_ce", ce_out, 3'b101);
        tick();
        check("badch_k1_ce", ce_out, 3'b000);
        repeat (3) tick();
        check("badch_k4_ce", ce_out, 3'b111);

        // Lock drop landing in ALIGN; outputs reset by t+3
        locked_in = 1'b0;
        tick();
        cfg_write(2'd2, 8'd2, 8'd1);
        tick();
        cfg_valid = 1'b0;
        check("drop_align_ce", ce_out, 3'b000);
        check("drop_align_locked", locked, 1);
        tick();
        check("drop_t3_locked", locked, 0);
        check("drop_t3_rstout", rst_out, 3'b111);
        check("drop_t3_ce", ce_out, 3'b000);
        check("drop_t3_ready", cfg_ready, 1);
`ifdef CLKEN_SQUARE_EN
        check("drop_t3_sq", sq_out, 3'b000);
`endif

        // Write in WAIT_LOCK: shadow only
        cfg_write(2'd0, 8'd0, 8'd0);
        tick();
        cfg_valid = 1'b0;
        check("wl_write_locked", locked, 0);
        check("wl_write_ready", cfg_ready, 1);

        // Relock with a one-cycle glitch at count 5
        locked_in = 1'b1;
        repeat (5) tick();
        locked_in = 1'b0;
        tick();
        locked_in = 1'b1;
        repeat (4) tick();
        check("glitch_t10_locked", locked, 0);
        repeat (5) tick();
        check("glitch_t15_locked", locked, 0);
        tick();
        check("glitch_t16_locked", locked, 1);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) tick();
            check($sformatf("relock_ce_k%0d", k), ce_out, ce_e[k]);
            check($sformatf("relock_rstout_k%0d", k), rst_out, rst_e[k]);
`ifdef CLKEN_SQUARE_EN
            check($sformatf("relock_sq_k%0d", k), sq_out, sq_e[k]);
`endif
        end

        // Reset in RUN
        rst = 1'b1;
        tick();
        check("rerst_locked", locked, 0);
        check("rerst_ce", ce_out, 3'b000);
        check("rerst_rstout", rst_out, 3'b111);
        check("rerst_ready", cfg_ready, 0);
        rst = 1'b0;
        tick();
        check("rerst_wl_ready", cfg_ready, 1);
        check("rerst_wl_locked", locked, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
